// File: rtl/write_bank_drain.sv
// write_bank_drain: drains num_rows bank rows, one byte lane per cycle, and packs the
// bytes little-endian into OUT_BYTES-wide words.
// Each word leaves on a valid/ready handshake at base_addr + word_index*OUT_BYTES.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin a drain (sampled in IDLE only)
//   num_rows, base_addr    drain length in rows and destination byte address
//                          (both latched on an accepted start)
//   bank_address           row presented to the bank
//   bank_read_sel          byte lane presented to the bank
//   bank_data              bank read byte, valid one cycle after address/sel
//   out_valid, out_ready   output word handshake
//   out_data, out_addr     output word and its destination byte address
//   busy                   high in any state other than IDLE
//   done                   one-cycle completion pulse
module write_bank_drain #(
    parameter int unsigned BANK_WIDTH             = 8,
    parameter int unsigned MEM_BUFFER_DEPTH_BYTES = 512,
    parameter int unsigned OUT_BYTES              = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [$clog2(MEM_BUFFER_DEPTH_BYTES):0]   num_rows,
    input  logic [31:0]                               base_addr,
    output logic [$clog2(MEM_BUFFER_DEPTH_BYTES)-1:0] bank_address,
    output logic [$clog2(BANK_WIDTH)-1:0]             bank_read_sel,
    input  logic [7:0]                                bank_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [8*OUT_BYTES-1:0]                    out_data,
    output logic [31:0]                               out_addr,
    output logic                                      busy,
    output logic                                      done
);

    localparam int unsigned AddrW       = $clog2(MEM_BUFFER_DEPTH_BYTES);
    localparam int unsigned RowsW       = AddrW + 1;
    localparam int unsigned LaneW       = $clog2(BANK_WIDTH);
    // One spare byte beyond a full word absorbs the read already in flight when the
    // output stalls, so no byte is ever dropped or re-read.
    localparam int unsigned BufBytes    = OUT_BYTES + 1;
    localparam int unsigned CntW        = $clog2(BufBytes + 1);
    localparam int unsigned WordsPerRow = BANK_WIDTH / OUT_BYTES;
    localparam int unsigned WordsW      = $clog2(MEM_BUFFER_DEPTH_BYTES * WordsPerRow + 1);
    localparam logic [CntW:0] RoomMax   = (CntW + 1)'(OUT_BYTES);

    typedef enum logic [1:0] {StIdle, StRead, StFlush, StDone} state_e;

    state_e                state_q, state_d;
    logic [AddrW-1:0]      addr_q, addr_d;
    logic [LaneW-1:0]      sel_q, sel_d;
    logic                  iss_q, iss_d;      // address presented this cycle is a live read
    logic                  rx_q;              // bank_data carries a live byte this cycle
    logic [RowsW-1:0]      rows_q, rows_d;
    logic [8*BufBytes-1:0] buf_q, buf_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [WordsW-1:0]     words_left_q, words_left_d;
    logic [31:0]           word_addr_q, word_addr_d;
    logic                  out_valid_q, out_valid_d;
    logic [8*OUT_BYTES-1:0] out_data_q, out_data_d;
    logic [31:0]           out_addr_q, out_addr_d;

    logic [8*BufBytes-1:0] ext;
    logic [CntW-1:0]       tot;
    logic [CntW:0]         room_sum;
    logic                  load, xfer, room, last_rd;

    always_comb begin
        // Buffer contents including the byte arriving this cycle.
        ext = buf_q;
        tot = cnt_q;
        if (rx_q) begin
            ext[{cnt_q, 3'b000} +: 8] = bank_data;
            tot = cnt_q + CntW'(1);
        end

        xfer = out_valid_q && out_ready;
        load = (tot >= CntW'(OUT_BYTES)) && (!out_valid_q || out_ready);

        buf_d       = ext;
        cnt_d       = tot;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        word_addr_d = word_addr_q;
        if (load) begin
            buf_d       = ext >> (8 * OUT_BYTES);
            cnt_d       = tot - CntW'(OUT_BYTES);
            out_valid_d = 1'b1;
            out_data_d  = ext[8*OUT_BYTES-1:0];
            out_addr_d  = word_addr_q;
            word_addr_d = word_addr_q + 32'(OUT_BYTES);
        end
        words_left_d = xfer ? words_left_q - WordsW'(1) : words_left_q;

        // Issue a read only if its byte is guaranteed a slot two cycles from now,
        // counting the read already in flight.
        room_sum = {1'b0, cnt_d} + {{CntW{1'b0}}, iss_q};
        room     = room_sum <= RoomMax;
        last_rd  = ({1'b0, addr_q} == rows_q - RowsW'(1)) && (sel_q == LaneW'(BANK_WIDTH - 1));

        state_d = state_q;
        iss_d   = 1'b0;
        addr_d  = addr_q;
        sel_d   = sel_q;
        rows_d  = rows_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rows_d       = num_rows;
                    word_addr_d  = base_addr;
                    words_left_d = WordsW'(num_rows) * WordsW'(WordsPerRow);
                    if (num_rows == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRead;
                        iss_d   = 1'b1;
                        addr_d  = '0;
                        sel_d   = '0;
                    end
                end
            end
            StRead: begin
                // addr_q/sel_q always name the most recently issued read here.
                if (last_rd) begin
                    state_d = StFlush;
                end else if (room) begin
                    iss_d = 1'b1;
                    if (sel_q == LaneW'(BANK_WIDTH - 1)) begin
                        sel_d  = '0;
                        addr_d = addr_q + AddrW'(1);
                    end else begin
                        sel_d = sel_q + LaneW'(1);
                    end
                end
            end
            StFlush: begin
                if (xfer && words_left_q == WordsW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            sel_q        <= '0;
            iss_q        <= 1'b0;
            rx_q         <= 1'b0;
            rows_q       <= '0;
            buf_q        <= '0;
            cnt_q        <= '0;
            words_left_q <= '0;
            word_addr_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            sel_q        <= sel_d;
            iss_q        <= iss_d;
            rx_q         <= iss_q;
            rows_q       <= rows_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            words_left_q <= words_left_d;
            word_addr_q  <= word_addr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
        end
    end

    assign bank_address  = addr_q;
    assign bank_read_sel = sel_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_addr      = out_addr_q;
    assign busy          = state_q != StIdle;
    assign done          = state_q == StDone;

endmodule

// File: doc/write_bank_drain.md
WRITE_BANK_DRAIN -- requirements
Module: write_bank_drain

Interface
REQ-001 SHALL have parameter BANK_WIDTH, default 8: bytes per bank row (the bank's byte lanes).
REQ-002 SHALL have parameter MEM_BUFFER_DEPTH_BYTES, default 512: rows per bank.
REQ-003 SHALL have parameter OUT_BYTES, default 4: bytes per output word; power of 2, at most BANK_WIDTH.
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk input 1, rising-edge clock.
REQ-005 SHALL have rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have start, input, 1 bit: begin a drain; sampled only in IDLE.
REQ-007 SHALL have num_rows, input, $clog2(MEM_BUFFER_DEPTH_BYTES)+1 bits: rows to drain, 0..MEM_BUFFER_DEPTH_BYTES; latched on accepted start.
REQ-008 SHALL have base_addr, input, 32 bits: destination byte address; latched on accepted start.
REQ-009 SHALL have bank_address, output, $clog2(MEM_BUFFER_DEPTH_BYTES) bits: row to the bank.
REQ-010 SHALL have bank_read_sel, output, $clog2(BANK_WIDTH) bits: byte lane to the bank.
REQ-011 SHALL have bank_data, input, 8 bits: bank read data, valid exactly 1 cycle after address/sel are presented.
REQ-012 SHALL have out_valid, input/output pair: out_valid output 1 bit, out_ready input 1 bit, valid/ready handshake.
REQ-013 SHALL have out_data, output, 8*OUT_BYTES bits: packed word, little-endian (first byte read in bits [7:0]).
REQ-014 SHALL have out_addr, output, 32 bits: base_addr + word_index*OUT_BYTES.
REQ-015 SHALL have busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have done, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, READ, FLUSH, DONE; IDLE->READ on start with num_rows>0; IDLE->DONE on start with num_rows==0.
REQ-018 SHALL read in order: row 0 lanes 0..BANK_WIDTH-1, then row 1, etc., through row num_rows-1.
REQ-019 SHALL issue one read per cycle in READ unless the returning byte could not be stored.
REQ-020 SHALL never drop, duplicate or reorder a byte under any out_ready pattern.
REQ-021 SHALL pack every OUT_BYTES consecutive bytes into one word.
REQ-022 SHALL assert out_valid once a completed word is moved into the output register.
REQ-023 SHALL hold out_data/out_addr stable while out_valid && !out_ready.
REQ-024 SHALL count a transfer only on a cycle with out_valid && out_ready.
REQ-025 SHALL allow a new completed word to load in the same cycle the previous word transfers (no bubble).
REQ-026 SHALL sustain 1 byte/cycle with out_ready held high: first out_valid OUT_BYTES+1 cycles after entering READ.
REQ-027 SHALL, once all reads are issued, enter FLUSH and wait for the final word's transfer.
REQ-028 SHALL move FLUSH->DONE on the last transfer, then DONE->IDLE after one cycle; done is high only in DONE.
REQ-029 SHALL ignore start while busy.
REQ-030 SHALL produce exactly num_rows*BANK_WIDTH/OUT_BYTES words per drain.
REQ-031 SHALL hold bank_address/bank_read_sel at their last value when not issuing reads.

Reset
REQ-032 SHALL on rst_n low, at any time including mid-drain, immediately force: state IDLE; out_valid 0; out_data 0; out_addr 0; busy 0; done 0; bank_address 0; bank_read_sel 0; internal counters and assembly register cleared.
REQ-033 SHALL, after reset release, generate no output until a new start.

Verification
REQ-034 SHALL verify: BANK_WIDTH=8, OUT_BYTES=4, byte value = row*8+lane, num_rows=2, base_addr=0x1000, out_ready=1 -> 4 words 0x03020100@0x1000, 0x07060504@0x1004, 0x0B0A0908@0x1008, 0x0F0E0D0C@0x100C; done pulses once; 16 consecutive read cycles.
REQ-035 SHALL verify: same drain with out_ready low for 10 cycles after the first out_valid -> word 0 held stable, reads stall, identical 4-word sequence, no loss.
REQ-036 SHALL verify: out_ready random at 50%, num_rows=64 -> 128 words in order, addresses incrementing by 4.
REQ-037 SHALL verify: num_rows=0 -> no out_valid; done high exactly 1 cycle, 1 cycle after the start cycle (the DONE cycle).
REQ-038 SHALL verify: start pulsed again mid-drain -> ignored, word count unchanged.
REQ-039 SHALL verify: rst_n asserted after word 1 -> all outputs 0 asynchronously; new start (num_rows=1) afterwards -> 2 fresh words from row 0.
